// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Desc     : Shared types and default latencies for the hazard controller.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit_if
//  Desc     : ID-stage hazard/stall bundle between pipeline and controller.
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_ctrl_unit_if;

    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       ID_useRs;
    logic       ID_useRt;
    logic       ID_isMulDiv;
    logic       ID_isDiv;
    logic       ID_isMfhilo;
    logic       branchTaken;
    logic [4:0] EX_Rd;
    logic       EX_memRead;

    logic       pcWrite;
    logic       IFID_write;
    logic       IFID_flush;
    logic       IDEX_bubble;
    logic       md_start;
    logic       md_isDiv;
    logic       hilo_write;
    logic       md_busy;

    // Pipeline side: drives the decode/execute status, consumes the controls.
    modport master (
        output ID_Rs, ID_Rt, ID_useRs, ID_useRt, ID_isMulDiv, ID_isDiv,
               ID_isMfhilo, branchTaken, EX_Rd, EX_memRead,
        input  pcWrite, IFID_write, IFID_flush, IDEX_bubble, md_start,
               md_isDiv, hilo_write, md_busy
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_useRs, ID_useRt, ID_isMulDiv, ID_isDiv,
               ID_isMfhilo, branchTaken, EX_Rd, EX_memRead,
        output pcWrite, IFID_write, IFID_flush, IDEX_bubble, md_start,
               md_isDiv, hilo_write, md_busy
    );

endinterface : hazard_ctrl_unit_if
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : md_sequencer
//  Desc     : MUL/DIV busy sequencer: counts unit latency, then pulses HI/LO write.
//  Revision : 1.0  initial release
// ============================================================================
module md_sequencer
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start,
    input  wire logic is_div,
    output logic      busy,
    output logic      hilo_write
);

    localparam int                 c_cnt_w    = $clog2(DIV_LAT + 1);
    localparam logic [c_cnt_w-1:0] c_mul_load = c_cnt_w'(MUL_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_div_load = c_cnt_w'(DIV_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Loading latency-1 gives exactly LAT cycles in MD_RUN before MD_DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = MD_RUN;
                    w_cnt_nxt   = is_div ? c_div_load : c_mul_load;
                end
            end
            MD_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = MD_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - c_one;
                end
            end
            MD_DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy       = (r_state != IDLE);
    assign hilo_write = (r_state == MD_DONE);

endmodule : md_sequencer
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_unit
//  Desc     : Load-use / MUL-DIV stall and branch flush control for the ID stage.
//             Define STALL_CNT_EN to add a saturating stall-cycle counter output.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_ctrl_unit_if.slave  bus
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    logic w_load_use;
    logic w_md_hold;
    logic w_stall;
    logic w_busy;
    logic w_hilo_write;
    logic w_md_start;

    assign w_load_use = bus.EX_memRead && (bus.EX_Rd != 5'd0) &&
                        ((bus.ID_useRs && (bus.EX_Rd == bus.ID_Rs)) ||
                         (bus.ID_useRt && (bus.EX_Rd == bus.ID_Rt)));

    assign w_md_hold  = (bus.ID_isMulDiv || bus.ID_isMfhilo) && w_busy;
    assign w_stall    = w_load_use || w_md_hold;

    // The MUL/DIV instruction itself advances; only a pending load blocks its launch.
    assign w_md_start = bus.ID_isMulDiv && !w_busy && !w_load_use;

    md_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_sequencer (
        .clk        (clk),
        .rst        (rst),
        .start      (w_md_start),
        .is_div     (bus.ID_isDiv),
        .busy       (w_busy),
        .hilo_write (w_hilo_write)
    );

    assign bus.pcWrite     = !w_stall;
    assign bus.IFID_write  = !w_stall;
    assign bus.IDEX_bubble = w_stall;
    assign bus.IFID_flush  = bus.branchTaken && !w_stall;
    assign bus.md_start    = w_md_start;
    assign bus.md_isDiv    = bus.ID_isDiv;
    assign bus.hilo_write  = w_hilo_write;
    assign bus.md_busy     = w_busy;

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule : hazard_ctrl_unit
`default_nettype wire
